// File: rtl/serial_alu_if.sv
// rtl/serial_alu_if.sv - control, flag and register-file bit-port bundle for serial_alu
interface serial_alu_if;
  // operation request / status
  logic       start;
  logic [2:0] op;
  logic       wb_en;
  logic       busy;
  logic       done;
  logic       flag_eq;
  logic       flag_lt;
  logic       flag_ltu;
  // bit-serial register-file port
  logic       op_a;
  logic       op_b;
  logic [4:0] bit_pos;
  logic       wr_en;
  logic       data_out;

  // requester and register file side
  modport master (
    output start, op, wb_en, op_a, op_b,
    input  busy, done, flag_eq, flag_lt, flag_ltu, bit_pos, wr_en, data_out
  );

  // ALU side
  modport slave (
    input  start, op, wb_en, op_a, op_b,
    output busy, done, flag_eq, flag_lt, flag_ltu, bit_pos, wr_en, data_out
  );
endinterface

// File: rtl/serial_alu.sv
// rtl/serial_alu.sv - bit-serial ALU: reads operands LSB first, optionally writes result back serially
module serial_alu #(
  parameter int D_WIDTH = 32
) (
  input logic         clk,
  input logic         rst,
  serial_alu_if.slave bus
);

  localparam int PW = $clog2(D_WIDTH);

  // Opcode map; 3'b111 is the "zero" operation.
  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_SUB  = 3'b001;
  localparam logic [2:0] OP_AND  = 3'b010;
  localparam logic [2:0] OP_OR   = 3'b011;
  localparam logic [2:0] OP_XOR  = 3'b100;
  localparam logic [2:0] OP_SLT  = 3'b101;
  localparam logic [2:0] OP_SLTU = 3'b110;

  typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

  state_t             state;
  state_t             nextState;
  logic [PW-1:0]      bitPos;
  logic [2:0]         opReg;
  logic               wbReg;
  logic               carry;
  logic               cmpCarry;
  logic               eqAcc;
  logic [D_WIDTH-1:0] result;
  logic               flagEq;
  logic               flagLt;
  logic               flagLtu;

  logic lastBit;
  logic opIsSub;
  logic startIsSub;
  logic bEff;
  logic sumBit;
  logic carryNext;
  logic cmpB;
  logic cmpSum;
  logic cmpCarryNext;
  logic resBit;
  logic ltNext;
  logic ltuNext;

  assign lastBit    = (bitPos == PW'(D_WIDTH - 1));
  assign opIsSub    = (opReg == OP_SUB) || (opReg == OP_SLT) || (opReg == OP_SLTU);
  assign startIsSub = (bus.op == OP_SUB) || (bus.op == OP_SLT) || (bus.op == OP_SLTU);

  // Per-bit datapath: operation adder plus an always-subtracting compare chain for the flags
  always_comb begin
    bEff         = opIsSub ? ~bus.op_b : bus.op_b;
    sumBit       = bus.op_a ^ bEff ^ carry;
    carryNext    = (bus.op_a & bEff) | (bus.op_a & carry) | (bEff & carry);
    cmpB         = ~bus.op_b;
    cmpSum       = bus.op_a ^ cmpB ^ cmpCarry;
    cmpCarryNext = (bus.op_a & cmpB) | (bus.op_a & cmpCarry) | (cmpB & cmpCarry);
    ltuNext      = ~cmpCarryNext;
    ltNext       = (bus.op_a & ~bus.op_b) | (~(bus.op_a ^ bus.op_b) & cmpSum);
    resBit       = 1'b0;
    case (opReg)
      OP_ADD, OP_SUB, OP_SLT, OP_SLTU: resBit = sumBit;
      OP_AND:                          resBit = bus.op_a & bus.op_b;
      OP_OR:                           resBit = bus.op_a | bus.op_b;
      OP_XOR:                          resBit = bus.op_a ^ bus.op_b;
      default:                         resBit = 1'b0;
    endcase
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= nextState;
  end

  // Next-state logic: READ and WRITE each last one full sweep of bit positions
  always_comb begin
    nextState = state;
    case (state)
      IDLE:    if (bus.start) nextState = READ;
      READ:    if (lastBit)   nextState = wbReg ? WRITE : DONE;
      WRITE:   if (lastBit)   nextState = DONE;
      DONE:    nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  // Datapath registers: operand capture, serial accumulation, flag capture on the last bit
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bitPos   <= '0;
      opReg    <= '0;
      wbReg    <= 1'b0;
      carry    <= 1'b0;
      cmpCarry <= 1'b0;
      eqAcc    <= 1'b0;
      result   <= '0;
      flagEq   <= 1'b0;
      flagLt   <= 1'b0;
      flagLtu  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            opReg    <= bus.op;
            wbReg    <= bus.wb_en;
            carry    <= startIsSub;
            cmpCarry <= 1'b1;
            eqAcc    <= 1'b1;
            result   <= '0;
            bitPos   <= '0;
          end
        end
        READ: begin
          bitPos   <= bitPos + 1'b1;
          carry    <= carryNext;
          cmpCarry <= cmpCarryNext;
          eqAcc    <= eqAcc & (bus.op_a == bus.op_b);
          if (lastBit) begin
            flagEq  <= eqAcc & (bus.op_a == bus.op_b);
            flagLt  <= ltNext;
            flagLtu <= ltuNext;
            if (opReg == OP_SLT)       result <= {{(D_WIDTH-1){1'b0}}, ltNext};
            else if (opReg == OP_SLTU) result <= {{(D_WIDTH-1){1'b0}}, ltuNext};
            else                       result <= {resBit, result[D_WIDTH-1:1]};
          end else begin
            result <= {resBit, result[D_WIDTH-1:1]};
          end
        end
        WRITE: begin
          bitPos <= bitPos + 1'b1;
        end
        default: begin
          bitPos <= '0;
        end
      endcase
    end
  end

  // Outputs decoded from state so that reset removes them without waiting for a clock
  assign bus.busy     = (state != IDLE);
  assign bus.wr_en    = (state == WRITE);
  assign bus.done     = (state == DONE);
  assign bus.data_out = (state == WRITE) & result[bitPos];
  assign bus.bit_pos  = bitPos;
  assign bus.flag_eq  = flagEq;
  assign bus.flag_lt  = flagLt;
  assign bus.flag_ltu = flagLtu;

endmodule

// File: tb/tb_serial_alu.sv
// tb/tb_serial_alu.sv - directed vector bench for serial_alu with a bit-serial register-file model
module tb_serial_alu;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  serial_alu_if bus ();

  serial_alu #(.D_WIDTH(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  logic [31:0] srcA;
  logic [31:0] srcB;
  logic [31:0] dest;
  int          writes  = 0;
  int          idleErr = 0;
  int          checks  = 0;
  int          fails   = 0;

  // register-file read ports
  assign bus.op_a = srcA[bus.bit_pos];
  assign bus.op_b = srcB[bus.bit_pos];

  // register-file write port
  always @(posedge clk) begin
    if (bus.wr_en) begin
      dest[bus.bit_pos] = bus.data_out;
      writes = writes + 1;
    end
  end

  // data_out must stay low outside write-back
  always @(negedge clk) begin
    if (!bus.wr_en && bus.data_out) idleErr = idleErr + 1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Issue one operation (caller is at a negedge) and wait for done; returns the done cycle
  // counted so that the accept edge is 0 and done is reported on the edge that samples it.
  task automatic runOp(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic wb, output int doneCyc, output int nWrites);
    int w0;
    srcA = a;
    srcB = b;
    bus.op = op;
    bus.wb_en = wb;
    bus.start = 1'b1;
    w0 = writes;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.op = ~op;
    bus.wb_en = ~wb;
    doneCyc = 0;
    for (int k = 1; k <= 100; k++) begin
      @(posedge clk);
      #1;
      if (bus.done) begin
        doneCyc = k + 1;
        break;
      end
    end
    nWrites = writes - w0;
  endtask

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        wb;
    logic [31:0] res;
    logic        eq;
    logic        lt;
    logic        ltu;
  } vec_t;

  vec_t vecs[10];

  initial begin
    int dc;
    int nw;
    int dones;
    int firstDone;
    int w0;
    int found;

    vecs[0] = '{3'b000, 32'hFFFFFFFF, 32'h00000001, 1'b1, 32'h00000000, 1'b0, 1'b1, 1'b0};
    vecs[1] = '{3'b001, 32'h00000005, 32'h00000007, 1'b1, 32'hFFFFFFFE, 1'b0, 1'b1, 1'b1};
    vecs[2] = '{3'b101, 32'h80000000, 32'h00000001, 1'b1, 32'h00000001, 1'b0, 1'b1, 1'b0};
    vecs[3] = '{3'b110, 32'h80000000, 32'h00000001, 1'b1, 32'h00000000, 1'b0, 1'b1, 1'b0};
    vecs[4] = '{3'b100, 32'h12345678, 32'h12345678, 1'b0, 32'h00000000, 1'b1, 1'b0, 1'b0};
    vecs[5] = '{3'b010, 32'hF0F0F0F0, 32'h3C3C3C3C, 1'b1, 32'h30303030, 1'b0, 1'b1, 1'b0};
    vecs[6] = '{3'b011, 32'hF0F0F0F0, 32'h0F0F0F0F, 1'b1, 32'hFFFFFFFF, 1'b0, 1'b1, 1'b0};
    vecs[7] = '{3'b111, 32'h00000007, 32'h00000007, 1'b1, 32'h00000000, 1'b1, 1'b0, 1'b0};
    vecs[8] = '{3'b000, 32'h7FFFFFFF, 32'h00000001, 1'b1, 32'h80000000, 1'b0, 1'b0, 1'b0};
    vecs[9] = '{3'b001, 32'h00000000, 32'h00000001, 1'b1, 32'hFFFFFFFF, 1'b0, 1'b1, 1'b1};

    rst = 1'b1;
    bus.start = 1'b0;
    bus.op = 3'b000;
    bus.wb_en = 1'b0;
    srcA = '0;
    srcB = '0;
    dest = '0;
    repeat (2) @(negedge clk);

    check("rst busy",     32'(bus.busy),     32'd0);
    check("rst done",     32'(bus.done),     32'd0);
    check("rst wr_en",    32'(bus.wr_en),    32'd0);
    check("rst data_out", 32'(bus.data_out), 32'd0);
    check("rst bit_pos",  32'(bus.bit_pos),  32'd0);
    check("rst flags",    32'({bus.flag_eq, bus.flag_lt, bus.flag_ltu}), 32'd0);

    // release and request on the same negedge: the first rising edge must accept
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      runOp(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].wb, dc, nw);
      check($sformatf("v%0d done_cycle", i), 32'(dc), vecs[i].wb ? 32'd65 : 32'd33);
      check($sformatf("v%0d writes", i), 32'(nw), vecs[i].wb ? 32'd32 : 32'd0);
      if (vecs[i].wb) check($sformatf("v%0d result", i), dest, vecs[i].res);
      check($sformatf("v%0d flag_eq", i),  32'(bus.flag_eq),  32'(vecs[i].eq));
      check($sformatf("v%0d flag_lt", i),  32'(bus.flag_lt),  32'(vecs[i].lt));
      check($sformatf("v%0d flag_ltu", i), 32'(bus.flag_ltu), 32'(vecs[i].ltu));
      @(posedge clk);
      #1;
      check($sformatf("v%0d done_pulse", i), 32'({bus.done, bus.busy}), 32'd0);
      @(negedge clk);
    end

    // start re-pulsed while busy, with a different op, must be ignored
    srcA = 32'd1;
    srcB = 32'd2;
    bus.op = 3'b000;
    bus.wb_en = 1'b1;
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    dones = 0;
    firstDone = 0;
    for (int k = 1; k <= 100; k++) begin
      @(posedge clk);
      #1;
      if (bus.done) begin
        dones++;
        if (firstDone == 0) firstDone = k + 1;
      end
      bus.start = (k == 4 || k == 19);
      bus.op = bus.start ? 3'b100 : 3'b000;
      bus.wb_en = ~bus.start;
    end
    bus.start = 1'b0;
    check("ignore dones",     32'(dones),     32'd1);
    check("ignore done_cyc",  32'(firstDone), 32'd65);
    check("ignore result",    dest,           32'd3);
    @(negedge clk);

    // reset in the middle of write-back
    srcA = 32'h0F0F0000;
    srcB = 32'h00001111;
    bus.op = 3'b000;
    bus.wb_en = 1'b1;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    found = 0;
    for (int k = 0; k < 100; k++) begin
      if (bus.wr_en && bus.bit_pos == 5'd10) begin
        found = 1;
        break;
      end
      @(negedge clk);
    end
    check("abort reached", 32'(found), 32'd1);
    rst = 1'b1;
    #1;
    check("abort wr_en",    32'(bus.wr_en),    32'd0);
    check("abort busy",     32'(bus.busy),     32'd0);
    check("abort data_out", 32'(bus.data_out), 32'd0);
    check("abort bit_pos",  32'(bus.bit_pos),  32'd0);
    check("abort flags",    32'({bus.flag_eq, bus.flag_lt, bus.flag_ltu}), 32'd0);
    w0 = writes;
    repeat (3) @(negedge clk);
    check("abort no writes", 32'(writes - w0), 32'd0);
    rst = 1'b0;
    runOp(3'b001, 32'd100, 32'd1, 1'b1, dc, nw);
    check("post done_cycle", 32'(dc), 32'd65);
    check("post writes",     32'(nw), 32'd32);
    check("post result",     dest,    32'd99);
    check("post flags",      32'({bus.flag_eq, bus.flag_lt, bus.flag_ltu}), 32'd0);
    @(negedge clk);

    check("data_out idle low", 32'(idleErr), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
